// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: hh:mm:ss time-setting FSM editing a BCD shadow, with blink, timeout and commit strobe.
// Optional auto-repeat from held up/down keys is built when CLOCK_SET_AUTOREPEAT_EN is defined.
module clock_set_ctrl #(
  parameter int CLK_HZ      = 1000,
  parameter int BLINK_HALF  = CLK_HZ / 4,
  parameter int TIMEOUT_S   = 10,
  parameter int REPEAT_DLY  = CLK_HZ / 2,
  parameter int REPEAT_RATE = CLK_HZ / 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_up_hold,
  input  logic        key_down_hold,
  input  logic [23:0] cur_bcd,
  output logic [23:0] disp_bcd,
  output logic [2:0]  twinkle_en,
  output logic        blink_phase,
  output logic        editing,
  output logic        load_en,
  output logic [23:0] load_bcd
);

  typedef enum logic [2:0] {RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  state_t        state, state_nxt;
  logic [23:0]   shadow, shadow_nxt;
  logic [7:0]    to_cnt, to_nxt;
  logic [BW-1:0] blk_cnt, blk_nxt;
  logic          ph_nxt, fld_chg, edit_nxt;
  logic          up_evt, dn_evt, key_any;
  logic          rpt_up, rpt_dn;

  // Two-digit BCD step; any nibble above 9 is treated as out of range.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max,
                                          input logic inc);
    logic bad;
    bad = (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max);
    if (inc) begin
      if (bad || v == max) return 8'h00;
      if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
    end
    if (bad || v == 8'h00) return max;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

`ifdef CLOCK_SET_AUTOREPEAT_EN
  logic [15:0] rpt_cnt, rpt_cnt_nxt;
  logic        rpt_run, rpt_armed, rpt_armed_nxt, rpt_dir;
  logic        rpt_fire, run_ok, run_cont;

  // Counts consecutive cycles of a single held key; the first repeat waits
  // REPEAT_DLY cycles, later ones REPEAT_RATE cycles.
  always_comb begin
    run_ok        = (state inside {EDIT_H, EDIT_M, EDIT_S}) &&
                    (key_up_hold ^ key_down_hold) && !key_mode;
    run_cont      = rpt_run && (rpt_dir == key_up_hold);
    rpt_fire      = 1'b0;
    rpt_cnt_nxt   = '0;
    rpt_armed_nxt = 1'b0;
    if (run_ok) begin
      rpt_armed_nxt = run_cont && rpt_armed;
      rpt_cnt_nxt   = (run_cont ? rpt_cnt : 16'd0) + 16'd1;
      if (rpt_cnt_nxt == (rpt_armed_nxt ? 16'(REPEAT_RATE) : 16'(REPEAT_DLY))) begin
        rpt_fire      = 1'b1;
        rpt_cnt_nxt   = '0;
        rpt_armed_nxt = 1'b1;
      end
    end
  end

  assign rpt_up = rpt_fire & key_up_hold;
  assign rpt_dn = rpt_fire & key_down_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_run   <= 1'b0;
      rpt_armed <= 1'b0;
      rpt_dir   <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_run   <= run_ok;
      rpt_armed <= rpt_armed_nxt;
      rpt_dir   <= key_up_hold;
    end
  end
`else
  localparam int unused_rpt = REPEAT_DLY + REPEAT_RATE;
  logic unused_hold;
  assign unused_hold = key_up_hold ^ key_down_hold;
  assign rpt_up      = 1'b0;
  assign rpt_dn      = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    to_nxt     = to_cnt;
    fld_chg    = 1'b0;
    up_evt     = key_up | rpt_up;
    dn_evt     = key_down | rpt_dn;
    key_any    = key_mode | up_evt | dn_evt;
    case (state)
      RUN: begin
        if (key_mode) begin
          state_nxt  = EDIT_H;
          shadow_nxt = cur_bcd;
          to_nxt     = '0;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (key_mode) begin
          state_nxt = (state == EDIT_H) ? EDIT_M : (state == EDIT_M) ? EDIT_S : COMMIT;
        end else if (up_evt ^ dn_evt) begin
          fld_chg = 1'b1;
          case (state)
            EDIT_H:  shadow_nxt[23:16] = bcd_step(shadow[23:16], 8'h23, up_evt);
            EDIT_M:  shadow_nxt[15:8]  = bcd_step(shadow[15:8],  8'h59, up_evt);
            default: shadow_nxt[7:0]   = bcd_step(shadow[7:0],   8'h59, up_evt);
          endcase
        end
        // A key in the same cycle as the expiring tick keeps the edit alive.
        if (key_any) begin
          to_nxt = '0;
        end else if (tick_1hz) begin
          if (to_cnt == 8'(TIMEOUT_S - 1)) begin
            state_nxt = RUN;
            to_nxt    = '0;
          end else begin
            to_nxt = to_cnt + 8'd1;
          end
        end
      end
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    edit_nxt = state_nxt inside {EDIT_H, EDIT_M, EDIT_S};
    blk_nxt  = blk_cnt + BW'(1);
    ph_nxt   = blink_phase;
    if (!edit_nxt || state == RUN || fld_chg) begin
      blk_nxt = '0;
      ph_nxt  = 1'b1;
    end else if (blk_cnt == BW'(BLINK_HALF - 1)) begin
      blk_nxt = '0;
      ph_nxt  = ~blink_phase;
    end
  end

  // Outputs are registered from next-state values so a key shows one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      shadow      <= '0;
      to_cnt      <= '0;
      blk_cnt     <= '0;
      blink_phase <= 1'b1;
      twinkle_en  <= 3'b000;
      editing     <= 1'b0;
      load_en     <= 1'b0;
      load_bcd    <= '0;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      to_cnt      <= to_nxt;
      blk_cnt     <= blk_nxt;
      blink_phase <= ph_nxt;
      twinkle_en  <= {state_nxt == EDIT_H, state_nxt == EDIT_M, state_nxt == EDIT_S};
      editing     <= edit_nxt;
      load_en     <= (state_nxt == COMMIT);
      if (state_nxt == COMMIT) load_bcd <= shadow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    disp_bcd <= (rst || state_nxt == RUN) ? cur_bcd : shadow_nxt;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, hand-written corner sequences and a randomized model comparison.
module tb_clock_set_ctrl;

  localparam int BH = 4;
  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst, tick_1hz, key_mode, key_up, key_down, key_up_hold, key_down_hold;
  logic [23:0] cur_bcd, disp_bcd, load_bcd;
  logic [2:0]  twinkle_en;
  logic        blink_phase, editing, load_en;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .CLK_HZ(16), .BLINK_HALF(BH), .TIMEOUT_S(TO), .REPEAT_DLY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .key_mode(key_mode), .key_up(key_up),
    .key_down(key_down), .key_up_hold(key_up_hold), .key_down_hold(key_down_hold),
    .cur_bcd(cur_bcd), .disp_bcd(disp_bcd), .twinkle_en(twinkle_en),
    .blink_phase(blink_phase), .editing(editing), .load_en(load_en), .load_bcd(load_bcd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: field index 0=idle,1=hour,2=min,3=sec,4=commit.
  int          m_st, m_to, m_age;
  logic [23:0] m_sh, e_disp, e_ldb;
  logic [2:0]  e_tw;
  bit          e_ed, e_ld, e_ph;

  function automatic logic [7:0] ref_adj(input logic [7:0] v, input int mx, input bit inc);
    int hi, lo, val, n;
    hi  = int'(v[7:4]);
    lo  = int'(v[3:0]);
    val = (hi > 9 || lo > 9) ? 99 : hi * 10 + lo;
    if (inc) n = (val >= mx) ? 0 : val + 1;
    else     n = (val == 0 || val > mx) ? mx : val - 1;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_step();
    int  prev;
    bit  changed;
    int  lo;
    prev    = m_st;
    changed = 0;
    if (rst) begin
      m_st = 0; m_sh = '0; m_to = 0; m_age = 0; e_ldb = '0;
    end else if (m_st == 0) begin
      if (key_mode) begin m_st = 1; m_sh = cur_bcd; m_to = 0; end
    end else if (m_st == 4) begin
      m_st = 0;
    end else begin
      if (key_mode) m_st = m_st + 1;
      else if (key_up != key_down) begin
        lo = (3 - m_st) * 8;
        m_sh[lo +: 8] = ref_adj(m_sh[lo +: 8], (m_st == 1) ? 23 : 59, key_up);
        changed = 1;
      end
      if (key_mode || key_up || key_down) m_to = 0;
      else if (tick_1hz) begin
        m_to++;
        if (m_to == TO) begin m_st = 0; m_to = 0; end
      end
    end
    if (m_st >= 1 && m_st <= 3) begin
      if (prev == 0 || changed) m_age = 0;
      else m_age++;
    end else m_age = 0;
    e_disp = (m_st == 0) ? cur_bcd : m_sh;
    e_tw   = (m_st == 1) ? 3'b100 : (m_st == 2) ? 3'b010 : (m_st == 3) ? 3'b001 : 3'b000;
    e_ed   = (m_st >= 1 && m_st <= 3);
    e_ld   = (m_st == 4);
    if (e_ld) e_ldb = m_sh;
    e_ph   = ((m_age / BH) % 2) == 0;
  endtask

  task automatic cyc(input bit cmp);
    @(posedge clk);
    model_step();
    #1;
    if (cmp) begin
      chk("m_disp", disp_bcd, e_disp);
      chk("m_twinkle", twinkle_en, e_tw);
      chk("m_editing", editing, e_ed);
      chk("m_load_en", load_en, e_ld);
      chk("m_blink", blink_phase, e_ph);
      if (e_ld) chk("m_load_bcd", load_bcd, e_ldb);
    end
  endtask

  task automatic drv(input bit r, input bit m, input bit u, input bit d, input bit t);
    rst = r; key_mode = m; key_up = u; key_down = d; tick_1hz = t;
    cyc(1);
  endtask

  typedef struct {
    bit          r, m, u, d, t;
    logic [23:0] disp;
    logic [2:0]  tw;
    bit          ed, ld, ph;
    logic [23:0] ldb;
  } vec_t;

  vec_t tbl[16];
  int   nld;
  logic [23:0] last_ld;
  logic [7:0]  exp_ss;

  initial begin
    rst = 1'b1; tick_1hz = 0; key_mode = 0; key_up = 0; key_down = 0;
    key_up_hold = 0; key_down_hold = 0; cur_bcd = 24'h123456;

    tbl[0]  = '{1,0,0,0,0, 24'h123456, 3'b000, 0,0,1, 24'h0};
    tbl[1]  = '{1,0,0,0,0, 24'h123456, 3'b000, 0,0,1, 24'h0};
    tbl[2]  = '{0,0,0,0,0, 24'h123456, 3'b000, 0,0,1, 24'h0};
    tbl[3]  = '{0,0,1,0,0, 24'h123456, 3'b000, 0,0,1, 24'h0};
    tbl[4]  = '{0,1,0,0,0, 24'h123456, 3'b100, 1,0,1, 24'h0};
    tbl[5]  = '{0,0,1,0,0, 24'h133456, 3'b100, 1,0,1, 24'h0};
    tbl[6]  = '{0,0,1,1,0, 24'h133456, 3'b100, 1,0,1, 24'h0};
    tbl[7]  = '{0,1,1,0,0, 24'h133456, 3'b010, 1,0,1, 24'h0};
    tbl[8]  = '{0,0,0,1,0, 24'h133356, 3'b010, 1,0,1, 24'h0};
    tbl[9]  = '{0,0,0,0,0, 24'h133356, 3'b010, 1,0,1, 24'h0};
    tbl[10] = '{0,0,0,0,0, 24'h133356, 3'b010, 1,0,1, 24'h0};
    tbl[11] = '{0,0,0,0,0, 24'h133356, 3'b010, 1,0,1, 24'h0};
    tbl[12] = '{0,0,0,0,0, 24'h133356, 3'b010, 1,0,0, 24'h0};
    tbl[13] = '{0,1,0,0,0, 24'h133356, 3'b001, 1,0,0, 24'h0};
    tbl[14] = '{0,1,0,0,0, 24'h133356, 3'b000, 0,1,1, 24'h133356};
    tbl[15] = '{0,0,0,0,0, 24'h123456, 3'b000, 0,0,1, 24'h0};

    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].r, tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].t);
      chk($sformatf("v%0d_disp", i), disp_bcd, tbl[i].disp);
      chk($sformatf("v%0d_twinkle", i), twinkle_en, tbl[i].tw);
      chk($sformatf("v%0d_editing", i), editing, tbl[i].ed);
      chk($sformatf("v%0d_load_en", i), load_en, tbl[i].ld);
      chk($sformatf("v%0d_blink", i), blink_phase, tbl[i].ph);
      if (tbl[i].ld) chk($sformatf("v%0d_load_bcd", i), load_bcd, tbl[i].ldb);
      if (i == 1) chk("rst_load_bcd", load_bcd, 24'h0);
    end

    // Full edit: hour +3, minute -35, commit once.
    drv(1,0,0,0,0);
    nld = 0; last_ld = '0;
    drv(0,1,0,0,0);
    for (int i = 0; i < 3; i++) drv(0,0,1,0,0);
    drv(0,1,0,0,0);
    for (int i = 0; i < 35; i++) drv(0,0,0,1,0);
    drv(0,1,0,0,0);
    for (int i = 0; i < 4; i++) begin
      drv(0, i == 0, 0,0,0);
      if (load_en) begin nld++; last_ld = load_bcd; end
    end
    chk("full_load_count", nld, 1);
    chk("full_load_bcd", last_ld, 24'h155956);
    chk("full_end_editing", editing, 0);

    // Wraps.
    cur_bcd = 24'h230000; drv(1,0,0,0,0);
    drv(0,1,0,0,0); drv(0,0,1,0,0);
    chk("wrap_h23_up", disp_bcd[23:16], 8'h00);
    drv(0,1,0,0,0); drv(0,0,0,1,0);
    chk("wrap_m00_dn", disp_bcd[15:8], 8'h59);
    cur_bcd = 24'h2A0000; drv(1,0,0,0,0);
    drv(0,1,0,0,0); drv(0,0,1,0,0);
    chk("wrap_h2A_up", disp_bcd[23:16], 8'h00);
    drv(1,0,0,0,0); drv(0,1,0,0,0); drv(0,0,0,1,0);
    chk("wrap_h2A_dn", disp_bcd[23:16], 8'h23);

    // Timeout after TO idle ticks.
    cur_bcd = 24'h123456; drv(1,0,0,0,0);
    drv(0,1,0,0,0); drv(0,0,1,0,0);
    drv(0,0,0,0,1); drv(0,0,0,0,0); drv(0,0,0,0,1); drv(0,0,0,0,0);
    chk("to_before", editing, 1);
    drv(0,0,0,0,1);
    chk("to_editing", editing, 0);
    chk("to_load_en", load_en, 0);
    chk("to_disp", disp_bcd, 24'h123456);
    cur_bcd = 24'h123457; drv(0,0,0,0,0);
    chk("to_disp_track", disp_bcd, 24'h123457);
    drv(0,1,0,0,0); drv(0,0,0,0,1); drv(0,0,0,0,1); drv(0,0,1,0,1);
    chk("to_key_wins", editing, 1);
    chk("to_key_processed", disp_bcd[23:16], 8'h13);
    drv(0,0,0,0,1); drv(0,0,0,0,1);
    chk("to_restarted", editing, 1);
    drv(0,0,0,0,1);
    chk("to_second_expire", editing, 0);

    // Reset in the seconds field.
    drv(0,1,0,0,0); drv(0,1,0,0,0); drv(0,1,0,0,0);
    chk("rst_es_twinkle", twinkle_en, 3'b001);
    drv(1,0,0,0,0);
    chk("rst_es_editing", editing, 0);
    chk("rst_es_twinkle0", twinkle_en, 3'b000);
    chk("rst_es_load_en", load_en, 0);
    drv(0,0,0,0,0);
    chk("rst_es_no_load", load_en, 0);

    // Held up key in the seconds field.
    cur_bcd = 24'h000010; drv(1,0,0,0,0);
    drv(0,1,0,0,0); drv(0,1,0,0,0); drv(0,1,0,0,0);
    key_up_hold = 1'b1;
    rst = 0; key_mode = 0; key_up = 0; key_down = 0; tick_1hz = 0;
    for (int i = 0; i < 10; i++) cyc(0);
    key_up_hold = 1'b0;
    cyc(0);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_ss = 8'h14;
`else
    exp_ss = 8'h10;
`endif
    chk("hold_ss", disp_bcd[7:0], exp_ss);
    chk("hold_editing", editing, 1);

    // Randomized run; busy and quiet phases alternate so timeouts also occur.
    drv(1,0,0,0,0);
    for (int i = 0; i < 4000; i++) begin
      bit quiet;
      quiet = ((i / 400) % 2) == 1;
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 7) == 0) cur_bcd = 24'($urandom);
        else cur_bcd = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                        to_bcd($urandom_range(0, 59))};
      end
`ifndef CLOCK_SET_AUTOREPEAT_EN
      key_up_hold   = $urandom_range(0, 1) == 1;
      key_down_hold = $urandom_range(0, 1) == 1;
`endif
      drv($urandom_range(0, 299) == 0,
          $urandom_range(0, quiet ? 30 : 8) == 0,
          $urandom_range(0, quiet ? 40 : 3) == 0,
          $urandom_range(0, quiet ? 40 : 4) == 0,
          $urandom_range(0, quiet ? 2 : 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the digital clock datapath. It sequences a user edit of hh:mm:ss from mode/up/down key strobes and edits a BCD shadow copy of the running time. It drives the display source (shadow or live) and per-field twinkle enables. When the user confirms, it commits the edit to the clock counter with a one-cycle load strobe. It sits between the key debouncers and the clock counter / tube+VGA display drive.

Parameters:
CLK_HZ, 1000, clk frequency in Hz; sets blink half-period.
BLINK_HALF, CLK_HZ/4, cycles per blink phase. Blink period is 2*BLINK_HALF.
TIMEOUT_S, 10, tick_1hz strobes with no key press before an edit is abandoned. Legal range 1..255.
REPEAT_DLY, CLK_HZ/2, cycles a hold level must persist before the first auto-repeat (macro builds only).
REPEAT_RATE, CLK_HZ/8, cycles between auto-repeats (macro builds only).

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  one-cycle strobe, 1 Hz
key_mode  in  1  debounced one-cycle press strobe: enter/advance field
key_up  in  1  one-cycle strobe: increment selected field
key_down  in  1  one-cycle strobe: decrement selected field
key_up_hold  in  1  debounced level, up key held (used only with macro)
key_down_hold  in  1  debounced level, down key held (used only with macro)
cur_bcd  in  24  live time {hh,mm,ss}, 2 BCD digits each
disp_bcd  out  24  value to display
twinkle_en  out  3  one-hot field under edit {hour,min,sec}; 000 when not editing
blink_phase  out  1  1 = show, 0 = blank; applied by display to twinkle_en fields
editing  out  1  high in any EDIT state
load_en  out  1  one-cycle commit strobe
load_bcd  out  24  value to load; valid when load_en=1

Behaviour:
- Reset values (rst high at a clock edge): state RUN; shadow 0; load_en 0; load_bcd 0; blink_phase 1; blink counter 0; timeout counter 0; twinkle_en 000; editing 0. Reset mid-edit discards the edit and issues no load.
- States: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT. All outputs are registered. Key strobe in cycle n takes effect at the outputs in cycle n+1.
- RUN + key_mode: go to EDIT_H and copy shadow <= cur_bcd on the same edge. key_up/key_down are ignored in RUN.
- EDIT_H + key_mode -> EDIT_M. EDIT_M + key_mode -> EDIT_S. EDIT_S + key_mode -> COMMIT.
- COMMIT lasts exactly 1 cycle: load_en=1, load_bcd=shadow. Next state is RUN.
- disp_bcd: shadow in EDIT_*/COMMIT, cur_bcd in RUN, delayed by 1 register stage. The live clock keeps running during an edit; the shadow does not.
- Field arithmetic uses 2-digit BCD. Max is 23 for hour and 59 for min/sec.
  - Increment: if value >= max -> 00; else if low digit = 9 -> high+1, low 0; else low+1.
  - Decrement: if value = 00 or value > max -> max; else if low digit = 0 -> high-1, low 9; else low-1.
  - Any nibble > 9 counts as value > max.
- Simultaneous events:
  - key_up and key_down in the same cycle: both ignored.
  - key_mode with key_up/key_down: key_mode wins and the field is not modified.
- Timeout:
  - The counter clears on entry to EDIT_H and on any key strobe while editing. It increments on tick_1hz while editing.
  - When it reaches TIMEOUT_S -> RUN with no load_en; the shadow is discarded.
  - A key strobe in the same cycle as the expiring tick clears the counter, and the key is processed.
- Blink:
  - The counter runs only while editing and wraps at BLINK_HALF-1, toggling blink_phase.
  - Counter is forced to 0 and blink_phase to 1 on entering EDIT_H, on any up/down change, and in RUN.
- twinkle_en: 100 in EDIT_H, 010 in EDIT_M, 001 in EDIT_S, 000 otherwise.

Optional Feature:
Macro CLOCK_SET_AUTOREPEAT_EN.
- Defined: while in EDIT_*, a hold level continuously high for REPEAT_DLY cycles generates an internal increment/decrement, then another every REPEAT_RATE cycles until the level drops.
  - Repeats behave exactly like key strobes, including timeout clear and blink reset.
  - Both hold levels high: no repeat.
  - Leaving the edit state or reset restarts the repeat counter.
- Undefined: hold ports are ignored (unconnected in logic); only strobes edit.

Test Plan:
- Reset: rst=1 for 2 cycles -> twinkle_en=000, editing=0, load_en=0, blink_phase=1, disp_bcd tracks cur_bcd=12:34:56 one cycle later.
- Full edit: cur_bcd=12:34:56, then mode, up×3 (hour 15), mode, down×35 (min 59), mode, mode -> exactly one load_en pulse with load_bcd=15:59:56, then RUN.
- Wrap: hour 23 + up -> 00; min 00 + down -> 59; invalid hour 2A + up -> 00, + down -> 23.
- Timeout: TIMEOUT_S=3, enter edit, change hour, 3 tick_1hz strobes with no key -> RUN at next cycle, no load_en, disp_bcd = cur_bcd.
- Simultaneous: key_up & key_down same cycle -> shadow unchanged; key_mode & key_up in EDIT_H -> EDIT_M, hour unchanged; rst during EDIT_S -> RUN, no load.
- With CLOCK_SET_AUTOREPEAT_EN, REPEAT_DLY=4, REPEAT_RATE=2: key_up_hold high 10 cycles in EDIT_S from ss=10 -> ss=14 (repeats at cycles 4, 6, 8, 10). Without the macro: ss stays 10.
